// File: rtl/l1_mmu_arbiter_if.sv
// Bundle of the I-cache, D-cache and MMU line-port signals around the arbiter.
// slave is the arbiter's view; master is the view of the caches/MMU around it.
interface l1_mmu_arbiter_if;
  logic         i_req_read;
  logic [31:0]  i_req_addr;
  logic         i_done;
  logic [255:0] i_read_data;

  logic         d_req_read;
  logic         d_req_write;
  logic [31:0]  d_req_addr;
  logic [255:0] d_write_data;
  logic         d_done;
  logic [255:0] d_read_data;

  logic         mmu_req_read;
  logic         mmu_req_write;
  logic [31:0]  mmu_req_addr;
  logic [255:0] mmu_write_data;
  logic         mmu_done;
  logic [255:0] mmu_read_data;

  logic         grant_i;
  logic         grant_d;

  modport slave (
    input  i_req_read, i_req_addr,
    output i_done, i_read_data,
    input  d_req_read, d_req_write, d_req_addr, d_write_data,
    output d_done, d_read_data,
    output mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data,
    input  mmu_done, mmu_read_data,
    output grant_i, grant_d
  );

  modport master (
    output i_req_read, i_req_addr,
    input  i_done, i_read_data,
    output d_req_read, d_req_write, d_req_addr, d_write_data,
    input  d_done, d_read_data,
    input  mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data,
    output mmu_done, mmu_read_data,
    input  grant_i, grant_d
  );
endinterface

// File: rtl/l1_mmu_arbiter.sv
// Shares one MMU line port between the L1 I-cache and D-cache: D-side priority,
// with a saturating starvation counter that promotes a waiting I-side read.
module l1_mmu_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              sys_clk,
  input  logic              rst,
  l1_mmu_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_next;

  logic             r_req_read;
  logic             r_req_write;
  logic [31:0]      r_req_addr;
  logic [255:0]     r_write_data;

  logic             w_i_pend;
  logic             w_d_pend;
  logic             w_pick_i;
  logic             w_pick_d;
  logic             w_owner_done;
  logic             w_unused_addr_lsbs;

  assign w_i_pend = bus.i_req_read;
  assign w_d_pend = bus.d_req_read | bus.d_req_write;
  // Line-aligned addresses: the byte offset bits are never forwarded.
  assign w_unused_addr_lsbs = ^{bus.i_req_addr[4:0], bus.d_req_addr[4:0]};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pick_i      = 1'b0;
    w_pick_d      = 1'b0;
    w_owner_done  = 1'b0;
    w_starve_next = r_starve_cnt;
    case (r_state)
      IDLE: begin
        if (w_i_pend && (r_starve_cnt >= LIMIT)) begin
          w_pick_i = 1'b1;
        end else if (w_d_pend) begin
          w_pick_d = 1'b1;
        end else if (w_i_pend) begin
          w_pick_i = 1'b1;
        end
        if (w_pick_i) begin
          w_state_next = GNT_I;
        end else if (w_pick_d) begin
          w_state_next = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (bus.mmu_done) begin
          w_owner_done = 1'b1;
          w_state_next = RELEASE;
        end
      end
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // A losing (or not-yet-served) I read ages every cycle; entering GNT_I clears it.
    if (w_i_pend && (r_state != GNT_I) && (r_starve_cnt < LIMIT)) begin
      w_starve_next = r_starve_cnt + 1'b1;
    end
    if (w_pick_i) begin
      w_starve_next = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_req_read   <= 1'b0;
      r_req_write  <= 1'b0;
      r_req_addr   <= '0;
      r_write_data <= '0;
    end else if (w_pick_i) begin
      r_req_read   <= 1'b1;
      r_req_write  <= 1'b0;
      r_req_addr   <= {bus.i_req_addr[31:5], 5'b0};
      r_write_data <= '0;
    end else if (w_pick_d) begin
      // Write-back wins when the D-cache raises both read and write.
      r_req_read   <= ~bus.d_req_write;
      r_req_write  <= bus.d_req_write;
      r_req_addr   <= {bus.d_req_addr[31:5], 5'b0};
      r_write_data <= bus.d_req_write ? bus.d_write_data : '0;
    end else if (w_owner_done) begin
      r_req_read   <= 1'b0;
      r_req_write  <= 1'b0;
      r_req_addr   <= '0;
      r_write_data <= '0;
    end
  end

  assign bus.mmu_req_read   = r_req_read;
  assign bus.mmu_req_write  = r_req_write;
  assign bus.mmu_req_addr   = r_req_addr;
  assign bus.mmu_write_data = r_write_data;

  assign bus.grant_i     = (r_state == GNT_I);
  assign bus.grant_d     = (r_state == GNT_D);
  assign bus.i_done      = bus.mmu_done & (r_state == GNT_I);
  assign bus.d_done      = bus.mmu_done & (r_state == GNT_D);
  assign bus.i_read_data = bus.mmu_read_data;
  assign bus.d_read_data = bus.mmu_read_data;

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Directed scenarios plus randomized traffic for l1_mmu_arbiter, checked every
// cycle against a transaction-level model of owner, release gap and starvation age.
module tb_l1_mmu_arbiter;

  localparam int LIMIT = 4;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  always #5 sys_clk = ~sys_clk;

  l1_mmu_arbiter_if bus ();

  l1_mmu_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // stimulus for the current cycle
  logic         s_rst = 1'b0;
  logic         s_ir  = 1'b0;
  logic [31:0]  s_ia  = '0;
  logic         s_dr  = 1'b0;
  logic         s_dw  = 1'b0;
  logic [31:0]  s_da  = '0;
  logic [255:0] s_dwd = '0;
  logic         s_md  = 1'b0;
  logic [255:0] s_mrd = '0;

  // reference model: who owns the port, whether the 1-cycle gap is pending,
  // how long the I side has been waiting, and the captured transaction
  int           m_owner   = 0;  // 0 none, 1 I, 2 D
  bit           m_gap     = 1'b0;
  int           m_starve  = 0;
  bit           m_wr      = 1'b0;
  logic [31:0]  m_addr    = '0;
  logic [255:0] m_wdata   = '0;
  bit           m_valid   = 1'b0;
  bit           m_i_done  = 1'b0;
  bit           m_d_done  = 1'b0;

  task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_outputs();
    m_i_done = (m_owner == 1) && s_md;
    m_d_done = (m_owner == 2) && s_md;
    if (!m_valid) return;
    check_value("grant_i", bus.grant_i, m_owner == 1);
    check_value("grant_d", bus.grant_d, m_owner == 2);
    check_value("mmu_req_read", bus.mmu_req_read, (m_owner != 0) && !m_wr);
    check_value("mmu_req_write", bus.mmu_req_write, (m_owner != 0) && m_wr);
    check_value("mmu_req_addr", bus.mmu_req_addr, (m_owner != 0) ? m_addr : 32'h0);
    if (m_owner != 0 && m_wr) check_value("mmu_write_data", bus.mmu_write_data, m_wdata);
    check_value("i_done", bus.i_done, m_i_done);
    check_value("d_done", bus.d_done, m_d_done);
    if (m_i_done) begin
      check_value("i_read_data", bus.i_read_data, s_mrd);
      $display("txn I read  addr=%08h", m_addr);
    end
    if (m_d_done) begin
      check_value("d_read_data", bus.d_read_data, s_mrd);
      $display("txn D %s addr=%08h", m_wr ? "write" : "read ", m_addr);
    end
  endtask

  task automatic model_step();
    bit take_i;
    bit take_d;
    if (s_rst) begin
      m_owner = 0; m_gap = 1'b0; m_starve = 0; m_wr = 1'b0; m_valid = 1'b1;
      return;
    end
    take_i = 1'b0;
    take_d = 1'b0;
    if (m_owner == 0 && !m_gap) begin
      if (s_ir && m_starve >= LIMIT) take_i = 1'b1;
      else if (s_dr || s_dw)         take_d = 1'b1;
      else if (s_ir)                 take_i = 1'b1;
    end
    if (s_ir && m_owner != 1 && m_starve < LIMIT) m_starve++;
    if (take_i) m_starve = 0;
    if (m_owner != 0) begin
      if (s_md) begin
        m_owner = 0;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (take_i) begin
      m_owner = 1; m_wr = 1'b0; m_addr = s_ia & ~32'h1F;
    end else if (take_d) begin
      m_owner = 2; m_wr = s_dw; m_addr = s_da & ~32'h1F; m_wdata = s_dwd;
    end
  endtask

  task automatic run_cycle();
    @(negedge sys_clk);
    rst                = s_rst;
    bus.i_req_read     = s_ir;
    bus.i_req_addr     = s_ia;
    bus.d_req_read     = s_dr;
    bus.d_req_write    = s_dw;
    bus.d_req_addr     = s_da;
    bus.d_write_data   = s_dwd;
    bus.mmu_done       = s_md;
    bus.mmu_read_data  = s_mrd;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic idle_inputs();
    s_rst = 1'b0; s_ir = 1'b0; s_dr = 1'b0; s_dw = 1'b0; s_md = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    s_rst = 1'b1;
    run_cycle();
    s_rst = 1'b0;
    run_cycle();
  endtask

  int first_i;
  int n_dg;
  int n_id;
  int n_dd;
  bit gd_after;
  bit i_act;
  bit d_act;

  initial begin
    // reset state
    do_reset();
    check_value("rst_grant_i", bus.grant_i, 1'b0);
    check_value("rst_grant_d", bus.grant_d, 1'b0);
    check_value("rst_mmu_rd", bus.mmu_req_read, 1'b0);
    check_value("rst_mmu_wr", bus.mmu_req_write, 1'b0);
    check_value("rst_mmu_addr", bus.mmu_req_addr, 32'h0);

    // I alone, with an address change while granted
    s_ir = 1'b1; s_ia = 32'h1000_0024;
    run_cycle();
    run_cycle();
    check_value("t1_grant_i", bus.grant_i, 1'b1);
    check_value("t1_addr", bus.mmu_req_addr, 32'h1000_0020);
    run_cycle();
    s_ia = 32'h3000_0000;
    run_cycle();
    run_cycle();
    s_md = 1'b1; s_mrd = rand_line();
    run_cycle();
    check_value("t1_i_done", bus.i_done, 1'b1);
    check_value("t5_addr_hold", bus.mmu_req_addr, 32'h1000_0020);
    s_md = 1'b0; s_ir = 1'b0;
    run_cycle();
    check_value("t1_rd_low_c6", bus.mmu_req_read, 1'b0);
    run_cycle();
    check_value("t1_idle_c7", bus.grant_i | bus.grant_d, 1'b0);

    // simultaneous I read and D write
    do_reset();
    s_ir = 1'b1; s_ia = 32'h1000_0040;
    s_dw = 1'b1; s_da = 32'h2000_0040; s_dwd = {8{32'hA5A5_0001}};
    run_cycle();
    run_cycle();
    check_value("t2_grant_d", bus.grant_d, 1'b1);
    check_value("t2_wr", bus.mmu_req_write, 1'b1);
    check_value("t2_wdata", bus.mmu_write_data, {8{32'hA5A5_0001}});
    s_md = 1'b1; s_mrd = rand_line();
    run_cycle();
    s_md = 1'b0; s_dw = 1'b0;
    run_cycle();
    run_cycle();
    check_value("t2_gap", bus.mmu_req_read, 1'b0);
    run_cycle();
    check_value("t2_i_issued", bus.mmu_req_read, 1'b1);
    check_value("t2_i_addr", bus.mmu_req_addr, 32'h1000_0040);
    s_md = 1'b1;
    run_cycle();
    idle_inputs();
    run_cycle();

    // starvation: D re-requests every IDLE, MMU answers at once
    do_reset();
    s_ir = 1'b1; s_ia = 32'h1000_0000;
    s_dr = 1'b1; s_da = 32'h2000_0000; s_md = 1'b1;
    first_i = -1; n_dg = 0; gd_after = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      run_cycle();
      if (bus.grant_d && first_i < 0) n_dg++;
      if (bus.grant_i && first_i < 0) first_i = k;
      if (k == 10) gd_after = bus.grant_d;
    end
    check_value("t3_first_i", 256'(first_i), 256'(7));
    check_value("t3_d_grants", 256'(n_dg), 256'(2));
    check_value("t3_cnt_cleared", gd_after, 1'b1);
    idle_inputs();
    run_cycle();
    run_cycle();

    // reset in the middle of a D write
    do_reset();
    s_dw = 1'b1; s_da = 32'h2000_0000; s_dwd = rand_line();
    run_cycle();
    run_cycle();
    run_cycle();
    check_value("t4_in_gnt_d", bus.grant_d, 1'b1);
    s_rst = 1'b1; s_dw = 1'b0;
    run_cycle();
    s_rst = 1'b0;
    run_cycle();
    check_value("t4_wr_cleared", bus.mmu_req_write, 1'b0);
    check_value("t4_grant_cleared", bus.grant_d, 1'b0);
    s_md = 1'b1;
    run_cycle();
    check_value("t4_no_d_done", bus.d_done, 1'b0);
    check_value("t4_no_i_done", bus.i_done, 1'b0);
    s_md = 1'b0;

    // D read and write both high
    do_reset();
    s_dr = 1'b1; s_dw = 1'b1; s_da = 32'h2000_0080; s_dwd = rand_line();
    n_id = 0; n_dd = 0;
    for (int k = 0; k < 7; k++) begin
      s_md = (k == 3);
      if (k == 4) begin s_dr = 1'b0; s_dw = 1'b0; end
      run_cycle();
      if (k == 1) begin
        check_value("t6_wr", bus.mmu_req_write, 1'b1);
        check_value("t6_rd", bus.mmu_req_read, 1'b0);
      end
      n_id += int'(bus.i_done);
      n_dd += int'(bus.d_done);
    end
    check_value("t6_d_done_cnt", 256'(n_dd), 256'(1));
    check_value("t6_i_done_cnt", 256'(n_id), 256'(0));

    // randomized traffic; caches mostly hold requests until done
    do_reset();
    i_act = 1'b0; d_act = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!i_act && $urandom_range(3) == 0) begin
        i_act = 1'b1; s_ia = $urandom;
      end else if (i_act && $urandom_range(15) == 0) begin
        s_ia = $urandom;
      end else if (i_act && $urandom_range(63) == 0) begin
        i_act = 1'b0;
      end
      if (!d_act && $urandom_range(1) == 0) begin
        d_act = 1'b1; s_da = $urandom; s_dwd = rand_line();
        s_dr = $urandom_range(1) == 1; s_dw = $urandom_range(1) == 1;
        if (!s_dr && !s_dw) s_dr = 1'b1;
      end else if (d_act && $urandom_range(15) == 0) begin
        s_da = $urandom; s_dwd = rand_line();
      end
      s_ir  = i_act;
      if (!d_act) begin s_dr = 1'b0; s_dw = 1'b0; end
      s_md  = $urandom_range(2) == 0;
      s_mrd = rand_line();
      s_rst = $urandom_range(399) == 0;
      if (s_rst) s_md = 1'b0;
      run_cycle();
      if (m_i_done || s_rst) i_act = 1'b0;
      if (m_d_done || s_rst) d_act = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
